spi_mux_ctrl: RTL and testbench
===============================

# spi_mux_ctrl

Parametrised SPI slave that generalises the single 8-bit analog-mux control register into a bank of NUM_CH addressable registers with readback and break-before-make output sequencing. It sits between the external SPI pins and the analog-mux switch array: SPI frames write or read per-channel switch words, and the block drives complementary switch-control buses (dout_p/dout_n) that never close a new switch before the switches being opened have opened.

## Interface
- DATA_W, 8, bits per channel register
- NUM_CH, 4, number of channel registers
- ADDR_W, 2, address bits in frame (2**ADDR_W ≥ NUM_CH)
- BBM_CYC, 4, clk cycles between turn-off and turn-on (≥1)
- RST_VAL, 0, reset value of every channel register
- clk  in  1  system clock, ≥8× SCK frequency
- rst  in  1  asynchronous, active-low reset
- sck  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clk
- mosi  in  1  SPI data in, MSB first
- ss  in  1  slave select, active low
- miso  out  1  SPI data out; 0 when ss high
- dout_p  out  NUM_CH*DATA_W  switch controls, channel k at [k*DATA_W +: DATA_W]
- dout_n  out  NUM_CH*DATA_W  always ~dout_p
- done  out  1  one-clk pulse on valid frame completion
- frame_err  out  1  one-clk pulse on bad-length frame at ss deassertion

## Operation
- Frame (FRAME_LEN = 1+ADDR_W+DATA_W bits): RW (1=read), ADDR MSB first, DATA MSB first. mosi sampled on synchronised sck rising edge.
- Frame FSM: IDLE -> CMD on ss fall; CMD -> ADDR after 1 bit; ADDR -> DATA after ADDR_W bits; DATA -> WAIT_SS after DATA_W bits; any state -> IDLE on ss rise. Extra bits in WAIT_SS set an overrun flag; bit counter saturates.
- On ss rise: exactly FRAME_LEN bits -> valid frame, done pulses; write to ADDR<NUM_CH commits DATA to reg[ADDR]; write to ADDR≥NUM_CH ignored (done still pulses). Any other bit count -> frame_err pulses, no register change.
- Read: on the sck falling edge after the last address bit, reg[ADDR] (0 if ADDR≥NUM_CH) loads into the shift-out register; MSB on miso, next bit on each following falling edge. miso=0 during CMD/ADDR, during write frames, and after the last data bit.
- Break-before-make: output FSM STABLE/BBM_WAIT. On commit, target T = all registers. Cycle after commit: dout_p <= dout_p & T (turn-offs applied), enter BBM_WAIT, counter=BBM_CYC. Counter reaches 0: dout_p <= T, -> STABLE. If the commit only turns bits off, BBM_WAIT still runs (no visible change at end).
- New commit during BBM_WAIT: turn-offs of new T applied to current dout_p next cycle, counter reloads to BBM_CYC, old pending turn-ons discarded.
- ss high for ≥3 clk between frames required; a shorter gap is not detected.

## Timing
- Reset (rst=0): all registers RST_VAL, dout_p=0, dout_n=all ones, miso=0, done=0, frame_err=0, FSMs IDLE/STABLE. After release, outputs follow registers only after a write commit.
- sck/mosi/ss pass 2 sync flops + 1 edge flop: edges act 3 clk after the pin edge.
- done/frame_err: 1 clk after ss rise detected (4 clk after pin).
- Turn-offs on dout: same cycle done is high; turn-ons BBM_CYC clk later.
- miso: updated 1 clk after falling-edge detect (≤4 clk after sck fall); valid at master's next rising edge given the clk ratio.
- rst assertion mid-frame: frame aborted, no commit, outputs to reset values immediately.

## Structure
- Package spi_mux_pkg: FRAME_LEN and bit-counter width localparams, RW_READ/RW_WRITE constants, frame-state enum (IDLE, CMD, ADDR, DATA, WAIT_SS), output-state enum (STABLE, BBM_WAIT).
- Sub-module spi_sync_edge: 2-flop synchroniser plus rise/fall pulse generation, instantiated for sck and ss (mosi uses sync only).

## Test plan
- Reset -> dout_p=0x00000000, dout_n=0xFFFFFFFF, miso=0; hold 20 clk, no change.
- Write ch2=0xA5 (frame 0_10_10100101) -> done pulse; dout_p[23:16]=0xA5 exactly 4 clk after done; other channels 0.
- BBM: ch0=0x0F then ch0=0xF0 -> on second done, dout_p[7:0]=0x00 for 4 clk, then 0xF0; dout_n=~dout_p every cycle.
- Read ch2 after A5 write (frame 1_10_xxxxxxxx) -> miso shifts 1,0,1,0,0,1,0,1; read ADDR=3 unwritten -> 0x00.
- Short frame (10 bits) and long frame (12 bits) -> frame_err pulse, no done, registers unchanged.
- Commit ch1=0xFF, during BBM_WAIT commit ch1=0x01 -> counter restarts, final dout_p[15:8]=0x01, never 0xFF; rst low mid-frame -> no commit, reset values.

Source files
------------

// File: rtl/spi_mux_pkg.sv
// Shared types and frame-geometry helpers for the SPI analog-mux controller.
package spi_mux_pkg;

   // Total bits in one frame: RW bit, address field, data field.
   function automatic int frame_len(input int addr_w, input int data_w);
      return 1 + addr_w + data_w;
   endfunction

   // Bit counter must reach FRAME_LEN+1 so an overlong frame is distinguishable.
   function automatic int bit_cnt_w(input int flen);
      return $clog2(flen + 2);
   endfunction

   localparam int DEF_DATA_W = 8;
   localparam int DEF_ADDR_W = 2;
   localparam int FRAME_LEN  = frame_len(DEF_ADDR_W, DEF_DATA_W);
   localparam int BIT_CNT_W  = bit_cnt_w(FRAME_LEN);

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CMD     = 3'd1,
      ADDR    = 3'd2,
      DATA    = 3'd3,
      WAIT_SS = 3'd4
   } frame_state_e;

   typedef enum logic {
      STABLE   = 1'b0,
      BBM_WAIT = 1'b1
   } out_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser with a third flop for rise/fall pulse generation.
module spi_sync_edge #(
   parameter logic RST_LVL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise,
   output logic fall
);

   logic s1_q, s2_q, s3_q;
   logic s1_d, s2_d, s3_d;

   // Next-state of the synchroniser chain.
   always_comb begin
      s1_d = din;
      s2_d = s1_q;
      s3_d = s2_q;
   end

   // Chain registers; reset to the pin's idle level so release makes no false edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q <= RST_LVL;
         s2_q <= RST_LVL;
         s3_q <= RST_LVL;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
         s3_q <= s3_d;
      end
   end

   assign rise = s2_q & ~s3_q;
   assign fall = ~s2_q & s3_q;

endmodule

// File: rtl/spi_mux_ctrl.sv
// SPI slave with a bank of channel registers, readback and break-before-make
// sequencing of complementary analog-mux switch controls.
module spi_mux_ctrl
   import spi_mux_pkg::*;
#(
   parameter int                DATA_W  = 8,
   parameter int                NUM_CH  = 4,
   parameter int                ADDR_W  = 2,
   parameter int                BBM_CYC = 4,
   parameter logic [DATA_W-1:0] RST_VAL = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     sck,
   input  logic                     mosi,
   input  logic                     ss,
   output logic                     miso,
   output logic [NUM_CH*DATA_W-1:0] dout_p,
   output logic [NUM_CH*DATA_W-1:0] dout_n,
   output logic                     done,
   output logic                     frame_err
);

   localparam int FLEN  = frame_len(ADDR_W, DATA_W);
   localparam int BC_W  = bit_cnt_w(FLEN);
   localparam int CNT_W = $clog2(BBM_CYC + 1);
   localparam int OUT_W = NUM_CH * DATA_W;

   logic sck_rise_s, sck_fall_s, ss_rise_s, ss_fall_s;
   logic mosi_s1_q, mosi_s2_q, mosi_s1_d, mosi_s2_d;

   frame_state_e      fstate_q, fstate_d;
   logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic              overrun_q, overrun_d;
   logic [FLEN-1:0]   shreg_q, shreg_d;
   logic              rw_q, rw_d;
   logic [DATA_W-1:0] sout_q, sout_d;
   logic              miso_q, miso_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] regs_q [NUM_CH];
   logic [DATA_W-1:0] regs_d [NUM_CH];

   out_state_e        ostate_q, ostate_d;
   logic [CNT_W-1:0]  bbm_cnt_q, bbm_cnt_d;
   logic [OUT_W-1:0]  dout_q, dout_d;
   logic [OUT_W-1:0]  dout_n_q, dout_n_d;

   logic [ADDR_W-1:0] f_addr_s;
   logic [DATA_W-1:0] f_data_s;
   logic [DATA_W-1:0] rd_val_s;
   logic              frame_ok_s;
   logic              wr_hit_s;
   logic              commit_s;
   logic [OUT_W-1:0]  tgt_s;

   spi_sync_edge #(.RST_LVL(1'b0)) u_sck_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (sck),
      .rise (sck_rise_s),
      .fall (sck_fall_s)
   );

   spi_sync_edge #(.RST_LVL(1'b1)) u_ss_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (ss),
      .rise (ss_rise_s),
      .fall (ss_fall_s)
   );

   // mosi only needs to be sampled in step with the synchronised sck edge.
   always_comb begin
      mosi_s1_d = mosi;
      mosi_s2_d = mosi_s1_q;
   end

   // mosi synchroniser registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mosi_s1_q <= 1'b0;
         mosi_s2_q <= 1'b0;
      end else begin
         mosi_s1_q <= mosi_s1_d;
         mosi_s2_q <= mosi_s2_d;
      end
   end

   // Frame decode: field extraction, validity, write target hit and readback mux.
   always_comb begin
      f_addr_s   = shreg_q[DATA_W +: ADDR_W];
      f_data_s   = shreg_q[DATA_W-1:0];
      frame_ok_s = (fstate_q != IDLE) && (bit_cnt_q == BC_W'(FLEN)) && !overrun_q;
      wr_hit_s   = 1'b0;
      rd_val_s   = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         wr_hit_s = wr_hit_s | (f_addr_s == ADDR_W'(k));
         rd_val_s = (shreg_q[ADDR_W-1:0] == ADDR_W'(k)) ? regs_q[k] : rd_val_s;
      end
      commit_s = ss_rise_s && frame_ok_s && (rw_q == RW_WRITE) && wr_hit_s;
   end

   // Frame FSM next state: bit collection, readback shifting and frame close-out.
   always_comb begin
      fstate_d  = fstate_q;
      bit_cnt_d = bit_cnt_q;
      overrun_d = overrun_q;
      shreg_d   = shreg_q;
      rw_d      = rw_q;
      sout_d    = sout_q;
      miso_d    = miso_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
         regs_d[k] = (commit_s && (f_addr_s == ADDR_W'(k))) ? f_data_s : regs_q[k];
      end

      if (ss_fall_s) begin
         fstate_d  = CMD;
         bit_cnt_d = '0;
         overrun_d = 1'b0;
         shreg_d   = '0;
         rw_d      = RW_WRITE;
         sout_d    = '0;
         miso_d    = 1'b0;
      end else if (ss_rise_s) begin
         fstate_d = IDLE;
         sout_d   = '0;
         miso_d   = 1'b0;
         if (fstate_q != IDLE) begin
            done_d = frame_ok_s;
            err_d  = !frame_ok_s;
         end else begin
            done_d = 1'b0;
            err_d  = 1'b0;
         end
      end else if (sck_rise_s && (fstate_q != IDLE)) begin
         bit_cnt_d = (bit_cnt_q == '1) ? bit_cnt_q : bit_cnt_q + BC_W'(1);
         case (fstate_q)
            CMD: begin
               shreg_d  = {shreg_q[FLEN-2:0], mosi_s2_q};
               rw_d     = mosi_s2_q;
               fstate_d = ADDR;
            end
            ADDR: begin
               shreg_d  = {shreg_q[FLEN-2:0], mosi_s2_q};
               fstate_d = (bit_cnt_q == BC_W'(ADDR_W)) ? DATA : ADDR;
            end
            DATA: begin
               shreg_d  = {shreg_q[FLEN-2:0], mosi_s2_q};
               fstate_d = (bit_cnt_q == BC_W'(FLEN - 1)) ? WAIT_SS : DATA;
            end
            WAIT_SS: begin
               overrun_d = 1'b1;
            end
            default: begin
               fstate_d = IDLE;
            end
         endcase
      end else if (sck_fall_s && (fstate_q == DATA) && (rw_q == RW_READ)) begin
         // First falling edge after the address loads the addressed register.
         if (bit_cnt_q == BC_W'(1 + ADDR_W)) begin
            miso_d = rd_val_s[DATA_W-1];
            sout_d = rd_val_s << 1;
         end else begin
            miso_d = sout_q[DATA_W-1];
            sout_d = sout_q << 1;
         end
      end else if (sck_fall_s) begin
         miso_d = 1'b0;
      end else begin
         miso_d = miso_q;
      end
   end

   // Frame FSM state, shift registers, channel registers and status pulses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fstate_q  <= IDLE;
         bit_cnt_q <= '0;
         overrun_q <= 1'b0;
         shreg_q   <= '0;
         rw_q      <= RW_WRITE;
         sout_q    <= '0;
         miso_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         for (int k = 0; k < NUM_CH; k++) begin
            regs_q[k] <= RST_VAL;
         end
      end else begin
         fstate_q  <= fstate_d;
         bit_cnt_q <= bit_cnt_d;
         overrun_q <= overrun_d;
         shreg_q   <= shreg_d;
         rw_q      <= rw_d;
         sout_q    <= sout_d;
         miso_q    <= miso_d;
         done_q    <= done_d;
         err_q     <= err_d;
         for (int k = 0; k < NUM_CH; k++) begin
            regs_q[k] <= regs_d[k];
         end
      end
   end

   // Break-before-make: open switches on commit, close new ones BBM_CYC cycles later.
   always_comb begin
      for (int k = 0; k < NUM_CH; k++) begin
         tgt_s[k*DATA_W +: DATA_W] = regs_d[k];
      end
      ostate_d  = ostate_q;
      bbm_cnt_d = bbm_cnt_q;
      dout_d    = dout_q;
      if (commit_s) begin
         // A commit during BBM_WAIT drops the old pending turn-ons and restarts.
         dout_d    = dout_q & tgt_s;
         bbm_cnt_d = CNT_W'(BBM_CYC);
         ostate_d  = BBM_WAIT;
      end else begin
         case (ostate_q)
            BBM_WAIT: begin
               if (bbm_cnt_q <= CNT_W'(1)) begin
                  dout_d    = tgt_s;
                  bbm_cnt_d = '0;
                  ostate_d  = STABLE;
               end else begin
                  bbm_cnt_d = bbm_cnt_q - CNT_W'(1);
               end
            end
            STABLE: begin
               dout_d = dout_q;
            end
            default: begin
               ostate_d = STABLE;
            end
         endcase
      end
      dout_n_d = ~dout_d;
   end

   // Output FSM state and registered complementary switch buses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ostate_q  <= STABLE;
         bbm_cnt_q <= '0;
         dout_q    <= '0;
         dout_n_q  <= '1;
      end else begin
         ostate_q  <= ostate_d;
         bbm_cnt_q <= bbm_cnt_d;
         dout_q    <= dout_d;
         dout_n_q  <= dout_n_d;
      end
   end

   assign miso      = miso_q;
   assign dout_p    = dout_q;
   assign dout_n    = dout_n_q;
   assign done      = done_q;
   assign frame_err = err_q;

endmodule

// File: tb/tb_spi_mux_ctrl.sv
// Scoreboard bench for spi_mux_ctrl: frame expectations are queued when a
// frame is driven and retired when the DUT pulses done/frame_err.
module tb_spi_mux_ctrl;

   localparam int HALF    = 8;
   localparam int BBM     = 4;
   localparam int BBM_L   = 400;

   logic        clk = 1'b0;
   logic        rst, sck, mosi, ss;
   logic        miso, done, frame_err;
   logic [31:0] dout_p, dout_n;
   logic        miso_l, done_l, err_l;
   logic [31:0] dout_p_l, dout_n_l;

   typedef struct {
      logic        is_err;
      logic        chk_rd;
      logic [7:0]  rd;
      logic [31:0] off;
      logic [31:0] on;
   } sb_ev_t;

   sb_ev_t      sb_q [$];
   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;
   int          done_cyc = 0;
   int          done_cnt = 0;
   int          err_cnt  = 0;
   logic        saw_ff_l = 1'b0;
   logic [7:0]  mdl_regs [4];
   logic [31:0] mdl_dout;

   spi_mux_ctrl u_dut (
      .clk       (clk),
      .rst       (rst),
      .sck       (sck),
      .mosi      (mosi),
      .ss        (ss),
      .miso      (miso),
      .dout_p    (dout_p),
      .dout_n    (dout_n),
      .done      (done),
      .frame_err (frame_err)
   );

   spi_mux_ctrl #(.BBM_CYC(BBM_L)) u_dut_long (
      .clk       (clk),
      .rst       (rst),
      .sck       (sck),
      .mosi      (mosi),
      .ss        (ss),
      .miso      (miso_l),
      .dout_p    (dout_p_l),
      .dout_n    (dout_n_l),
      .done      (done_l),
      .frame_err (err_l)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (done) done_cnt <= done_cnt + 1;
      if (frame_err) err_cnt <= err_cnt + 1;
      if (dout_p_l[15:8] == 8'hFF) saw_ff_l <= 1'b1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] mdl_flat();
      logic [31:0] r;
      for (int k = 0; k < 4; k++) r[k*8 +: 8] = mdl_regs[k];
      return r;
   endfunction

   // Drive one frame MSB first; capture miso of both DUTs just before each rising sck.
   task automatic spi_frame(input logic [15:0] bits, input int nbits,
                            output logic [15:0] cap, output logic [15:0] cap_l);
      cap = '0;
      cap_l = '0;
      ss = 1'b0;
      repeat (HALF) @(negedge clk);
      for (int i = nbits - 1; i >= 0; i--) begin
         mosi = bits[i];
         repeat (HALF) @(negedge clk);
         cap   = {cap[14:0], miso};
         cap_l = {cap_l[14:0], miso_l};
         sck = 1'b1;
         repeat (HALF) @(negedge clk);
         sck = 1'b0;
      end
      repeat (HALF) @(negedge clk);
      check_eq("miso_after_frame", miso, 1'b0);
      ss = 1'b1;
   endtask

   task automatic do_frame(input logic [15:0] bits, input int nbits);
      sb_ev_t      ev;
      sb_ev_t      got;
      logic [15:0] cap, cap_l;
      logic [31:0] tgt, exp_p, exp_n;
      logic        seen;
      ev.is_err = (nbits != 11);
      ev.chk_rd = 1'b0;
      ev.rd     = 8'h00;
      if (!ev.is_err && (bits[10] == 1'b0)) begin
         mdl_regs[bits[9:8]] = bits[7:0];
         tgt    = mdl_flat();
         ev.off = mdl_dout & tgt;
         ev.on  = tgt;
      end else begin
         ev.off    = mdl_dout;
         ev.on     = mdl_dout;
         ev.chk_rd = !ev.is_err;
         ev.rd     = mdl_regs[bits[9:8]];
      end
      sb_q.push_back(ev);
      spi_frame(bits, nbits, cap, cap_l);
      seen = 1'b0;
      for (int w = 0; w < 20 && !seen; w++) begin
         @(negedge clk);
         seen = done | frame_err;
      end
      got = sb_q.pop_front();
      if (!seen) begin
         check_eq("event_timeout", 1'b0, 1'b1);
      end else begin
         done_cyc = cyc;
         exp_n = ~got.off;
         check_eq("done", done, !got.is_err);
         check_eq("frame_err", frame_err, got.is_err);
         check_eq("done_long", done_l, !got.is_err);
         check_eq("err_long", err_l, got.is_err);
         check_eq("dout_turn_off", dout_p, got.off);
         check_eq("dout_n_turn_off", dout_n, exp_n);
         if (got.chk_rd) begin
            check_eq("rd_data", cap[7:0], got.rd);
            check_eq("rd_miso_lead", cap[10:8], 3'b000);
            check_eq("rd_data_long", cap_l[7:0], got.rd);
         end
         for (int i = 1; i <= BBM; i++) begin
            @(negedge clk);
            if (i == 1) begin
               check_eq("done_width", done, 1'b0);
               check_eq("err_width", frame_err, 1'b0);
            end
            exp_p = (i < BBM) ? got.off : got.on;
            exp_n = ~exp_p;
            check_eq((i < BBM) ? "dout_bbm_hold" : "dout_turn_on", dout_p, exp_p);
            check_eq("dout_n_compl", dout_n, exp_n);
         end
         mdl_dout = got.on;
      end
      repeat (4) @(negedge clk);
   endtask

   initial begin
      logic [31:0] e_n;
      int          on_cyc;
      int          dc0, ec0;
      rst = 1'b0; ss = 1'b1; sck = 1'b0; mosi = 1'b0;
      for (int k = 0; k < 4; k++) mdl_regs[k] = 8'h00;
      mdl_dout = 32'h0;
      repeat (5) @(negedge clk);
      check_eq("rst_dout_p", dout_p, 32'h0000_0000);
      check_eq("rst_dout_n", dout_n, 32'hFFFF_FFFF);
      check_eq("rst_miso", miso, 1'b0);
      check_eq("rst_done", done, 1'b0);
      check_eq("rst_frame_err", frame_err, 1'b0);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         repeat (5) @(negedge clk);
         check_eq("idle_dout_p", dout_p, 32'h0000_0000);
         check_eq("idle_dout_n", dout_n, 32'hFFFF_FFFF);
      end
      check_eq("idle_no_pulses", done_cnt + err_cnt, 0);

      // Writes, including a turn-off/turn-on swap on ch0.
      do_frame(16'b0_10_10100101, 11);
      do_frame(16'b0_00_00001111, 11);
      do_frame(16'b0_00_11110000, 11);

      // Readback of a written and an unwritten channel.
      do_frame(16'b1_10_00000000, 11);
      do_frame(16'b1_11_00000000, 11);

      // Bad-length frames leave everything untouched.
      do_frame(16'b0_11_1111111, 10);
      do_frame(16'b0_11_11111111_1, 12);
      do_frame(16'b1_11_00000000, 11);

      // Let the long-BBM instance settle, then overlap two commits on ch1.
      repeat (BBM_L + 20) @(negedge clk);
      e_n = ~mdl_dout;
      check_eq("long_settled", dout_p_l, mdl_dout);
      check_eq("long_settled_n", dout_n_l, e_n);
      do_frame(16'b0_01_11111111, 11);
      check_eq("long_ch1_off", dout_p_l[15:8], 8'h00);
      do_frame(16'b0_01_00000001, 11);
      on_cyc = -1;
      while (cyc < done_cyc + BBM_L + 10) begin
         @(negedge clk);
         if (on_cyc < 0 && dout_p_l[15:8] != 8'h00) on_cyc = cyc;
      end
      check_eq("long_restart_delay", on_cyc - done_cyc, BBM_L);
      check_eq("long_never_ff", saw_ff_l, 1'b0);
      check_eq("long_final", dout_p_l, mdl_dout);

      // Reset in the middle of a write frame.
      dc0 = done_cnt;
      ec0 = err_cnt;
      ss = 1'b0;
      repeat (HALF) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         mosi = (i == 1 || i == 2) ? 1'b1 : 1'b0;
         repeat (HALF) @(negedge clk);
         sck = 1'b1;
         repeat (HALF) @(negedge clk);
         sck = 1'b0;
      end
      rst = 1'b0;
      #1;
      check_eq("midrst_dout_p", dout_p, 32'h0000_0000);
      check_eq("midrst_dout_n", dout_n, 32'hFFFF_FFFF);
      check_eq("midrst_miso", miso, 1'b0);
      check_eq("midrst_long", dout_p_l, 32'h0000_0000);
      ss = 1'b1;
      mosi = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      repeat (20) @(negedge clk);
      check_eq("midrst_no_done", done_cnt - dc0, 0);
      check_eq("midrst_no_err", err_cnt - ec0, 0);
      check_eq("midrst_hold", dout_p, 32'h0000_0000);
      for (int k = 0; k < 4; k++) mdl_regs[k] = 8'h00;
      mdl_dout = 32'h0;
      do_frame(16'b1_10_00000000, 11);
      do_frame(16'b0_10_01011010, 11);

      check_eq("sb_empty", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
